// File: rtl/fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue of {pc, instruction} pairs.
// Keeps at most one bus request outstanding and supports redirects with a fetch in flight.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ibus_valid,
  input  logic                       ibus_ready,
  output logic [XLEN-1:0]            ibus_address,
  output logic [XLEN-1:0]            ibus_lookahead,
  input  logic [XLEN-1:0]            ibus_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_rdata,
  input  logic                       jump_valid,
  input  logic [XLEN-1:0]            jump_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned     IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // fetch_pc_q is the address of the pending request unless discarding, in which case
  // it already holds the redirect target while req_addr_q keeps the stale address.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            pending_q, pending_d;
  logic            discard_q, discard_d;

  logic complete;
  logic push;
  logic pop;

  always_comb begin
    complete = pending_q && ibus_ready;
    push     = complete && !discard_q && !jump_valid;
    pop      = (count_q != '0) && out_ready && !jump_valid;
  end

  // Queue pointers and occupancy; a redirect empties the queue and swallows any pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (jump_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = (head_q == LastIdx) ? '0 : head_q + IdxW'(1);
      end
      if (push) begin
        tail_d = (tail_q == LastIdx) ? '0 : tail_q + IdxW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch address, request and discard tracking.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pending_d  = pending_q;
    discard_d  = discard_q;

    if (jump_valid) begin
      fetch_pc_d = jump_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    if (complete) begin
      discard_d = 1'b0;
    end else if (jump_valid && pending_q) begin
      discard_d = 1'b1;
    end

    // A request, once raised, is held until the bus accepts it.
    if (!pending_q || complete) begin
      pending_d  = (count_d < Full);
      req_addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_pc[tail_q]   <= req_addr_q;
      mem_data[tail_q] <= ibus_rdata;
    end
  end

  always_comb begin
    ibus_valid   = pending_q;
    ibus_address = req_addr_q;
    if (jump_valid) begin
      ibus_lookahead = jump_pc;
    end else if (pending_q && !discard_q) begin
      ibus_lookahead = fetch_pc_q + PC_STEP;
    end else begin
      ibus_lookahead = fetch_pc_q;
    end
    out_valid = (count_q != '0);
    out_pc    = mem_pc[head_q];
    out_rdata = mem_data[head_q];
    level     = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: the bus model returns a known word per address, the stimulus
// queues expected pcs and a negedge monitor checks every popped entry in order.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ibus_valid;
  logic        ibus_ready;
  logic [31:0] ibus_address;
  logic [31:0] ibus_lookahead;
  logic [31:0] ibus_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_rdata;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_pc = '0;
  logic [2:0]  level;

  // Bus ready source: 0 = always ready, 1 = every third cycle, 2 = manual.
  int          mode = 0;
  logic        man_ready = 1'b0;
  int          slow_cnt = 0;

  int dir_cmp = 0;
  int dir_err = 0;
  int mon_cmp = 0;
  int mon_err = 0;

  logic [31:0] sb[$];

  logic [31:0] prev_addr = '0;
  logic        prev_wait = 1'b0;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .ibus_valid     (ibus_valid),
    .ibus_ready     (ibus_ready),
    .ibus_address   (ibus_address),
    .ibus_lookahead (ibus_lookahead),
    .ibus_rdata     (ibus_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_rdata      (out_rdata),
    .jump_valid     (jump_valid),
    .jump_pc        (jump_pc),
    .level          (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[31:16]};
  endfunction

  assign ibus_rdata = word(ibus_address);
  assign ibus_ready = (mode == 2) ? man_ready : ((mode == 0) || (slow_cnt == 2));

  always @(posedge clk) slow_cnt <= (slow_cnt == 2) ? 0 : slow_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_cmp++;
    if (act !== exp) begin
      dir_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ibus(input int max, input string name);
    for (int i = 0; i < max && !ibus_valid; i++) tick();
    chk({name, "_valid"}, 32'(ibus_valid), 32'd1);
  endtask

  task automatic bus_complete();
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Monitor: checks popped entries against the scoreboard and request stability.
  always @(negedge clk) begin
    if (reset || jump_valid) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        mon_cmp++;
        if (!ibus_valid || ibus_address !== prev_addr) begin
          mon_err++;
          $display("FAIL addr_stable: got valid=%b addr=%h, expected valid=1 addr=%h",
                   ibus_valid, ibus_address, prev_addr);
        end
      end
      if (out_valid && out_ready) begin
        mon_cmp++;
        if (sb.size() == 0) begin
          mon_err++;
          $display("FAIL unexpected_pop: got pc=%h, expected no entry", out_pc);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (out_pc !== e || out_rdata !== word(e)) begin
            mon_err++;
            $display("FAIL pop: got pc=%h data=%h, expected pc=%h data=%h",
                     out_pc, out_rdata, e, word(e));
          end
        end
      end
    end
    prev_wait = ibus_valid && !ibus_ready && !reset && !jump_valid;
    prev_addr = ibus_address;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: fill from reset with a fast bus and a stalled consumer.
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ibus_valid", 32'(ibus_valid), 32'd0);
    tick();
    reset = 1'b0;
    expect_run(32'h0, 64);
    wait_ibus(4, "first_req");
    chk("first_addr", ibus_address, 32'h0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_pc", out_pc, 32'h0);
    chk("t1_b2b_addr", ibus_address, 32'h4);
    repeat (5) tick();
    chk("t1_full_level", 32'(level), 32'd4);
    chk("t1_full_ibus_valid", 32'(ibus_valid), 32'd0);

    // 2: streaming, one push and one pop per cycle.
    out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      chk("t2_level", 32'(level), 32'd3);
      chk("t2_out_valid", 32'(out_valid), 32'd1);
      tick();
    end

    // 3: slow bus, ready every third cycle.
    mode = 1;
    repeat (30) tick();

    // 4: redirect while a request to 0x8 is pending.
    mode = 2;
    man_ready = 1'b0;
    reset = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
    expect_run(32'h0, 2);
    wait_ibus(4, "t4_req0");
    chk("t4_addr0", ibus_address, 32'h0);
    bus_complete();
    chk("t4_addr4", ibus_address, 32'h4);
    bus_complete();
    chk("t4_addr8", ibus_address, 32'h8);
    chk("t4_level_pre", 32'(level), 32'd1);
    jump_valid = 1'b1;
    jump_pc = 32'h100;
    sb.delete();
    expect_run(32'h100, 16);
    #1;
    chk("t4_lookahead_jump", ibus_lookahead, 32'h100);
    tick();
    jump_valid = 1'b0;
    #1;
    chk("t4_hold_valid", 32'(ibus_valid), 32'd1);
    chk("t4_hold_addr", ibus_address, 32'h8);
    chk("t4_level_flushed", 32'(level), 32'd0);
    chk("t4_lookahead_discard", ibus_lookahead, 32'h100);
    tick();
    bus_complete();
    chk("t4_redirect_valid", 32'(ibus_valid), 32'd1);
    chk("t4_redirect_addr", ibus_address, 32'h100);
    chk("t4_dropped_level", 32'(level), 32'd0);
    mode = 0;
    repeat (10) tick();

    // 5: redirect coinciding with a completion and a pop at level 3.
    out_ready = 1'b0;
    repeat (8) tick();
    chk("t5_full_level", 32'(level), 32'd4);
    chk("t5_full_ibus_valid", 32'(ibus_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    jump_valid = 1'b1;
    jump_pc = 32'h200;
    sb.delete();
    expect_run(32'h200, 16);
    #1;
    chk("t5_level_pre", 32'(level), 32'd3);
    chk("t5_completing", 32'(ibus_valid && ibus_ready), 32'd1);
    chk("t5_lookahead", ibus_lookahead, 32'h200);
    tick();
    jump_valid = 1'b0;
    chk("t5_level_post", 32'(level), 32'd0);
    chk("t5_out_valid_post", 32'(out_valid), 32'd0);
    chk("t5_next_addr", ibus_address, 32'h200);
    repeat (6) tick();

    // 6: address wrap, then reset in the middle of a fill.
    jump_valid = 1'b1;
    jump_pc = 32'hFFFF_FFFC;
    sb.delete();
    sb.push_back(32'hFFFF_FFFC);
    expect_run(32'h0, 15);
    tick();
    jump_valid = 1'b0;
    wait_ibus(3, "t6_wrap_req");
    chk("t6_wrap_addr_hi", ibus_address, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_addr_lo", ibus_address, 32'h0);
    repeat (6) tick();
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    sb.delete();
    tick();
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ibus_valid", 32'(ibus_valid), 32'd0);
    reset = 1'b0;
    expect_run(32'h0, 16);
    wait_ibus(4, "t6_restart");
    chk("t6_restart_addr", ibus_address, 32'h0);
    out_ready = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             dir_cmp + mon_cmp, dir_err + mon_err);
    $finish;
  end

endmodule
